// File: rtl/ex_stage_pkg.sv
// Shared opcode/select encodings and divider FSM state codes for the execute stage.
package ex_stage_pkg;
    localparam int REG_W      = 32;
    localparam int DIV_CYCLES = 32;

    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_DIV   = 3'b110;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_BUSY = 2'b10,
        DIV_DONE = 2'b11
    } div_state_t;
endpackage

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider: one quotient bit per cycle over a 64-bit {remainder, quotient} register.
module ex_stage_div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        busy
);
    div_state_t  state;
    logic [4:0]  count;
    logic [63:0] work;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;
    logic        sgn1;
    logic        sgn2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] trial;
    logic [31:0] quo;
    logic [31:0] rem;

    assign sgn1  = signed_div & opdata1[31];
    assign sgn2  = signed_div & opdata2[31];
    assign abs1  = sgn1 ? (~opdata1 + 32'd1) : opdata1;
    assign abs2  = sgn2 ? (~opdata2 + 32'd1) : opdata2;
    // Remainder with the next dividend bit shifted in, minus the divisor; bit 32 set means "does not fit".
    assign trial = work[63:31] - {1'b0, divisor};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DIV_IDLE;
            count   <= 5'd0;
            work    <= 64'd0;
            divisor <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (annul) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        divisor <= abs2;
                        count   <= 5'd0;
                        if (opdata2 == 32'd0) begin
                            work  <= {opdata1, 32'hFFFF_FFFF};
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DIV_ZERO;
                        end else begin
                            work  <= {32'd0, abs1};
                            neg_q <= sgn1 ^ sgn2;
                            neg_r <= sgn1;
                            state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    work  <= trial[32] ? {work[62:0], 1'b0} : {trial[31:0], work[30:0], 1'b1};
                    count <= count + 5'd1;
                    if (count == 5'(DIV_CYCLES - 1))
                        state <= DIV_DONE;
                end
                DIV_ZERO: state <= DIV_DONE;
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign quo    = work[31:0];
    assign rem    = work[63:32];
    // Magnitudes were divided; restore signs only when the result is presented.
    assign result = {(neg_r ? (~rem + 32'd1) : rem), (neg_q ? (~quo + 32'd1) : quo)};
    assign ready  = (state == DIV_DONE) & ~annul;
    assign busy   = ~annul & (((state == DIV_IDLE) & start) | (state == DIV_BUSY) | (state == DIV_ZERO));
endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: combinational logic/shift results plus a stalling divider.
// Define EX_SIGNED_DIV_EN to support the signed DIV op; otherwise only DIVU is executed.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);
    logic signed [31:0] reg2_s;
    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic        logic_hit;
    logic        shift_hit;
    logic        div_op;
    logic        signed_div;
    logic [63:0] div_result;
    logic        div_ready;
    logic        div_busy;

    assign reg2_s = reg2_i;

    always_comb begin
        logic_res = 32'd0;
        logic_hit = 1'b0;
        case (aluop_i)
            EXE_OR_OP:  begin logic_res = reg1_i | reg2_i;    logic_hit = 1'b1; end
            EXE_AND_OP: begin logic_res = reg1_i & reg2_i;    logic_hit = 1'b1; end
            EXE_XOR_OP: begin logic_res = reg1_i ^ reg2_i;    logic_hit = 1'b1; end
            EXE_NOR_OP: begin logic_res = ~(reg1_i | reg2_i); logic_hit = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        shift_res = 32'd0;
        shift_hit = 1'b0;
        case (aluop_i)
            EXE_SLL_OP: begin shift_res = reg2_i << reg1_i[4:0];  shift_hit = 1'b1; end
            EXE_SRL_OP: begin shift_res = reg2_i >> reg1_i[4:0];  shift_hit = 1'b1; end
            EXE_SRA_OP: begin shift_res = reg2_s >>> reg1_i[4:0]; shift_hit = 1'b1; end
            default: ;
        endcase
    end

`ifdef EX_SIGNED_DIV_EN
    assign signed_div = (aluop_i == EXE_DIV_OP);
    assign div_op     = (alusel_i == EXE_RES_DIV) &&
                        ((aluop_i == EXE_DIVU_OP) || (aluop_i == EXE_DIV_OP));
`else
    assign signed_div = 1'b0;
    assign div_op     = (alusel_i == EXE_RES_DIV) && (aluop_i == EXE_DIVU_OP);
`endif

    ex_stage_div_unit u_div_unit (
        .clk        (clk),
        .rst        (rst),
        .start      (div_op),
        .signed_div (signed_div),
        .opdata1    (reg1_i),
        .opdata2    (reg2_i),
        .annul      (flush_i),
        .result     (div_result),
        .ready      (div_ready),
        .busy       (div_busy)
    );

    // Everything is forced to zero while reset is asserted, including the address passthrough.
    always_comb begin
        wdata_o = 32'd0;
        wreg_o  = 1'b0;
        if (rst) begin
            case (alusel_i)
                EXE_RES_LOGIC: if (logic_hit) begin wdata_o = logic_res; wreg_o = wreg_i; end
                EXE_RES_SHIFT: if (shift_hit) begin wdata_o = shift_res; wreg_o = wreg_i; end
                default: ;
            endcase
        end
    end

    assign wd_o       = rst ? wd_i : 5'd0;
    assign whilo_o    = rst & div_ready;
    assign hi_o       = whilo_o ? div_result[63:32] : 32'd0;
    assign lo_o       = whilo_o ? div_result[31:0] : 32'd0;
    assign stallreq_o = rst & div_busy;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with a divide-result scoreboard.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        flush;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .alusel_i   (alusel),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .flush_i    (flush),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic w);
        @(posedge clk);
        #1;
        aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
    endtask

    task automatic check_alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_data, input logic exp_wreg);
        drive(op, sel, a, b, 5'd5, 1'b1);
        @(negedge clk);
        check({tag, " wdata"}, wdata_o, exp_data);
        check({tag, " wreg"}, 32'(wreg_o), 32'(exp_wreg));
        check({tag, " wd"}, 32'(wd_o), 32'd5);
    endtask

    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        exp_t e;
        exp_t got;
        int   stalls;
        bit   seen;
        e.stall = (b == 32'd0) ? 2 : 33;
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
        end else if (op == EXE_DIV_OP) begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        sb.push_back(e);
        drive(op, EXE_RES_DIV, a, b, 5'd9, 1'b1);
        stalls = 0;
        seen   = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(negedge clk);
            if (whilo_o) begin
                seen = 1'b1;
                got  = sb.pop_front();
                check({tag, " lo"}, lo_o, got.lo);
                check({tag, " hi"}, hi_o, got.hi);
                check({tag, " stall cycles"}, 32'(stalls), 32'(got.stall));
                check({tag, " stall at done"}, 32'(stallreq_o), 32'd0);
                check({tag, " wreg"}, 32'(wreg_o), 32'd0);
                check({tag, " wd"}, 32'(wd_o), 32'd9);
            end else begin
                if (stallreq_o) stalls++;
                // Operands after accept must not matter.
                if (cyc == 1) begin
                    reg1 = $urandom;
                    reg2 = $urandom;
                end
            end
        end
        check({tag, " completed"}, 32'(seen), 32'd1);
        if (!seen) sb.delete();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic watch_quiet(input string tag);
        int pulses;
        int stalls;
        pulses = 0;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (whilo_o) pulses++;
            if (stallreq_o) stalls++;
        end
        check({tag, " whilo pulses"}, 32'(pulses), 32'd0);
        check({tag, " late stalls"}, 32'(stalls), 32'd0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0;
        aluop = EXE_DIVU_OP; alusel = EXE_RES_DIV;
        reg1 = 32'd100; reg2 = 32'd7; wd = 5'd3; wreg = 1'b1;
        repeat (3) @(negedge clk);
        check("reset stallreq", 32'(stallreq_o), 32'd0);
        check("reset whilo", 32'(whilo_o), 32'd0);
        check("reset hi", hi_o, 32'd0);
        check("reset lo", lo_o, 32'd0);
        check("reset wreg", 32'(wreg_o), 32'd0);
        check("reset wd", 32'(wd_o), 32'd0);
        aluop = EXE_NOP_OP; alusel = EXE_RES_NOP;
        @(posedge clk);
        #1 rst = 1'b1;

        check_alu("or",  EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000_1100, 32'h0000_0011, 32'h0000_1111, 1'b1);
        check_alu("and", EXE_AND_OP, EXE_RES_LOGIC, 32'h0F0F_F0F0, 32'h00FF_FF00, 32'h000F_F000, 1'b1);
        check_alu("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b1);
        check_alu("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0000_000F, 32'hFFFF_FF00, 1'b1);
        check_alu("sll", EXE_SLL_OP, EXE_RES_SHIFT, 32'd4, 32'h0000_0001, 32'h0000_0010, 1'b1);
        check_alu("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b1);
        check_alu("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b1);
        check_alu("sra31", EXE_SRA_OP, EXE_RES_SHIFT, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_alu("unknown", 8'hEE, EXE_RES_LOGIC, 32'h1234_5678, 32'h1, 32'd0, 1'b0);
        check_alu("nop", EXE_NOP_OP, EXE_RES_NOP, 32'h1234_5678, 32'h1, 32'd0, 1'b0);

        run_div("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7);
        run_div("divu big", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h0001_0000);
        run_div("divu small/large", EXE_DIVU_OP, 32'd5, 32'hFFFF_FFF0);
        run_div("divu x/0", EXE_DIVU_OP, 32'hDEAD_BEEF, 32'd0);

        // Flush while BUSY with count=10.
        drive(EXE_DIVU_OP, EXE_RES_DIV, 32'd1000, 32'd3, 5'd9, 1'b0);
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush stallreq", 32'(stallreq_o), 32'd0);
        check("flush whilo", 32'(whilo_o), 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        aluop = EXE_NOP_OP; alusel = EXE_RES_NOP;
        watch_quiet("after flush");

        // Asynchronous reset while BUSY with count=10.
        drive(EXE_DIVU_OP, EXE_RES_DIV, 32'd1000, 32'd3, 5'd9, 1'b0);
        repeat (11) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async rst stallreq", 32'(stallreq_o), 32'd0);
        check("async rst whilo", 32'(whilo_o), 32'd0);
        aluop = EXE_NOP_OP; alusel = EXE_RES_NOP;
        @(posedge clk);
        #1 rst = 1'b1;
        watch_quiet("after reset");
        run_div("divu after reset", EXE_DIVU_OP, 32'd1000, 32'd3);

`ifdef EX_SIGNED_DIV_EN
        run_div("div -7/2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2);
        run_div("div 7/-2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE);
        run_div("div -100/-7", EXE_DIV_OP, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
`else
        drive(EXE_DIV_OP, EXE_RES_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
        @(negedge clk);
        check("div disabled stallreq", 32'(stallreq_o), 32'd0);
        check("div disabled wreg", 32'(wreg_o), 32'd0);
        check("div disabled wdata", wdata_o, 32'd0);
        @(posedge clk);
        #1 aluop = EXE_NOP_OP; alusel = EXE_RES_NOP;
        watch_quiet("div disabled");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
